silent_step_scheduler: RTL and testbench
========================================

# silent_step_scheduler

Sweep controller for the silent (low-pass) duty/phase smoothing datapath. On each ultrasound-period START it walks all DEPTH transducers once, reading target and current duty/phase from external RAMs. It moves each current value one STEP toward its target through a single shared step unit, and writes the result back. The block sits between the modulation/target memory and the PWM generator's duty/phase state RAM in the CLK (50 MHz) domain.

## Interface
Parameters:
- WIDTH, 13, duty/phase/cycle bit width
- DEPTH, 249, number of transducers
- AW, $clog2(DEPTH), address width

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  period strobe, level may last several cycles; rising edge triggers a sweep
- ENABLE  in  1  1 = smoothing, 0 = bypass (write target directly)
- STEP  in  WIDTH  maximum change per period, latched at sweep start
- RD_EN  out  1  read strobe to target and state RAMs
- RD_ADDR  out  AW  shared read address
- TGT_DUTY, TGT_PHASE, CYCLE  in  WIDTH  target RAM data, valid 1 cycle after RD_EN
- CUR_DUTY, CUR_PHASE  in  WIDTH  state RAM data, valid 1 cycle after RD_EN
- WR_EN  out  1  state RAM write strobe
- WR_ADDR  out  AW  write address
- WR_DUTY, WR_PHASE  out  WIDTH  smoothed values
- BUSY  out  1  sweep in progress
- DONE  out  1  one-cycle pulse at sweep end
- OVERRUN  out  1  sticky: START edge seen while BUSY

## Operation
- FSM states: IDLE, SWEEP, DRAIN.
  - IDLE -> SWEEP on START rising edge (START & ~start_q).
  - SWEEP -> DRAIN after RD_ADDR = DEPTH-1 is issued.
  - DRAIN -> IDLE after the last write, with DONE pulsed.
- SWEEP issues one read per cycle, addresses 0..DEPTH-1 in order, with no gaps.
- Duty rule:
  - d = TGT - CUR, computed at WIDTH+1 bits signed.
  - If |d| <= STEP, write TGT.
  - Otherwise write CUR + STEP (d > 0) or CUR - STEP (d < 0).
- Phase rule (circular modulo CYCLE, shortest path):
  - f = (TGT - CUR) mod CYCLE.
  - If f == 0, write TGT.
  - If f <= CYCLE/2 (floor), step forward: result is CUR+STEP, wrapping by subtracting CYCLE when >= CYCLE. If f <= STEP, write TGT.
  - Otherwise step backward: result is CUR-STEP, wrapping by adding CYCLE when < 0. If CYCLE-f <= STEP, write TGT.
- ENABLE=0 for the whole sweep (latched at start): WR_DUTY=TGT_DUTY, WR_PHASE=TGT_PHASE.
- STEP=0 with ENABLE=1: values are written back unchanged.
- START edge while BUSY: ignored, OVERRUN set. OVERRUN clears only on RST.
- Read and write addresses never coincide within a sweep, since writes lag reads by 2, so there is no RAM hazard.

## Timing
- Reset values: RD_EN=0, RD_ADDR=0, WR_EN=0, WR_ADDR=0, WR_DUTY=0, WR_PHASE=0, BUSY=0, DONE=0, OVERRUN=0, state IDLE, start_q=0.
- START edge detected in cycle k. After edge k: RD_EN=1, RD_ADDR=0, BUSY=1.
- RAM data valid during cycle k+1.
- After edge k+2: WR_EN=1, WR_ADDR=0 (read-to-write latency 2).
- Last read: RD_ADDR=DEPTH-1 after edge k+DEPTH-1. RD_EN=0 after edge k+DEPTH.
- Last write: WR_ADDR=DEPTH-1 after edge k+DEPTH+1.
- After edge k+DEPTH+2: WR_EN=0, BUSY=0, DONE=1 for one cycle.
- Sweep length is DEPTH+2 cycles (251 cycles, within the 1250-cycle period).
- RST asserted mid-sweep: all outputs return to reset values immediately. Entries already written stay modified; the next START restarts from address 0.

## Structure
- Shared package silent_pkg holds:
  - the state enum (IDLE/SWEEP/DRAIN)
  - the DEPTH/WIDTH defaults
  - the step-result typedef (WIDTH-bit duty and phase pair)
- Sub-module silent_step_unit holds the duty and circular phase step arithmetic, registered one stage, with inputs STEP, CYCLE, CUR_*, TGT_*. It is reused in the pipeline. The scheduler owns the FSM, address counter, and pipeline valid/address shift registers.

## Test plan
- Reset, then START edge with DEPTH=249: writes to addresses 0..248 in order, WR_EN high exactly 249 consecutive cycles, first write 2 cycles after first read, DONE 1 pulse, BUSY high 251 cycles.
- Duty clamping, CYCLE=5000, STEP=100:
  - CUR=0, TGT=250 -> 100, 200, 250, 250 over four sweeps.
  - CUR=300, TGT=250 -> 250.
- Phase wrap, CYCLE=5000, STEP=100:
  - CUR=4950, TGT=50 -> 50 (f=100).
  - CUR=4950, TGT=200 -> 50.
  - CUR=100, TGT=4900 -> 0, then 4900.
- ENABLE=0, random targets -> one sweep gives state == target for all 249 entries. Random targets with ENABLE=1, STEP=100 -> state == target after ceil(5000/100)+1 = 51 sweeps.
- START held high for 4 cycles -> exactly one sweep. Second START edge at cycle 50 of a sweep -> ignored, OVERRUN=1 until RST.
- RST pulse at WR_ADDR=120 -> outputs zero immediately, entries 0..120 updated, 121..248 untouched. Next START gives a full clean sweep.

Source files
------------

// File: rtl/silent_pkg.sv
// Shared types and defaults for the silent duty/phase smoothing sweep.
package silent_pkg;

  localparam int unsigned SILENT_WIDTH = 13;
  localparam int unsigned SILENT_DEPTH = 249;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [SILENT_WIDTH-1:0] duty;
    logic [SILENT_WIDTH-1:0] phase;
  } step_res_t;

endpackage

// File: rtl/silent_step_unit.sv
// One-stage step unit: moves duty linearly and phase circularly (mod cycle)
// one step toward target; bypass writes the target straight through.
module silent_step_unit
  import silent_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    enable_i,
  input  logic [SILENT_WIDTH-1:0] step_i,
  input  logic [SILENT_WIDTH-1:0] cycle_i,
  input  logic [SILENT_WIDTH-1:0] cur_duty_i,
  input  logic [SILENT_WIDTH-1:0] cur_phase_i,
  input  logic [SILENT_WIDTH-1:0] tgt_duty_i,
  input  logic [SILENT_WIDTH-1:0] tgt_phase_i,
  output step_res_t               res_o
);

  localparam int unsigned W  = SILENT_WIDTH;
  localparam int unsigned WE = SILENT_WIDTH + 1;

  logic [WE-1:0] d_diff, d_mag;
  logic [WE-1:0] f_dist, f_back, f_fwd, f_bwd;
  logic [W-1:0]  half_cycle;
  logic [W-1:0]  duty_c, phase_c;
  step_res_t     res_q;

  // Duty: signed difference, clamp the move to one step.
  always_comb begin
    duty_c = tgt_duty_i;
    d_diff = WE'(tgt_duty_i) - WE'(cur_duty_i);
    d_mag  = d_diff[W] ? (WE'(0) - d_diff) : d_diff;
    if (enable_i && (d_mag > WE'(step_i))) begin
      duty_c = d_diff[W] ? (cur_duty_i - step_i) : (cur_duty_i + step_i);
    end
  end

  // Phase: forward distance mod cycle, then take the shorter direction.
  always_comb begin
    phase_c    = tgt_phase_i;
    half_cycle = cycle_i >> 1;
    f_dist     = (tgt_phase_i >= cur_phase_i)
               ? (WE'(tgt_phase_i) - WE'(cur_phase_i))
               : (WE'(tgt_phase_i) + WE'(cycle_i) - WE'(cur_phase_i));
    f_back     = WE'(cycle_i) - f_dist;
    f_fwd      = WE'(cur_phase_i) + WE'(step_i);
    if (f_fwd >= WE'(cycle_i)) begin
      f_fwd = f_fwd - WE'(cycle_i);
    end
    f_bwd = (cur_phase_i >= step_i)
          ? (WE'(cur_phase_i) - WE'(step_i))
          : (WE'(cur_phase_i) + WE'(cycle_i) - WE'(step_i));
    if (enable_i && (f_dist != '0)) begin
      if (f_dist <= WE'(half_cycle)) begin
        if (f_dist > WE'(step_i)) phase_c = W'(f_fwd);
      end else if (f_back > WE'(step_i)) begin
        phase_c = W'(f_bwd);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q <= '0;
    end else if (en_i) begin
      res_q <= '{duty: duty_c, phase: phase_c};
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/silent_step_scheduler.sv
// Per-period sweep over all transducers: read target/current, step once,
// write back two cycles later through the shared step unit.
module silent_step_scheduler
  import silent_pkg::*;
#(
  parameter int unsigned WIDTH = SILENT_WIDTH,
  parameter int unsigned DEPTH = SILENT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ENABLE,
  input  logic [WIDTH-1:0] STEP,
  output logic             RD_EN,
  output logic [AW-1:0]    RD_ADDR,
  input  logic [WIDTH-1:0] TGT_DUTY,
  input  logic [WIDTH-1:0] TGT_PHASE,
  input  logic [WIDTH-1:0] CYCLE,
  input  logic [WIDTH-1:0] CUR_DUTY,
  input  logic [WIDTH-1:0] CUR_PHASE,
  output logic             WR_EN,
  output logic [AW-1:0]    WR_ADDR,
  output logic [WIDTH-1:0] WR_DUTY,
  output logic [WIDTH-1:0] WR_PHASE,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERRUN
);

  state_e           state_q, state_d;
  logic             start_q;
  logic             rd_en_q, rd_en_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             v1_q, wr_en_q;
  logic [AW-1:0]    a1_q, wr_addr_q;
  logic             busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             enable_q, enable_d;
  logic             start_edge_c, last_rd_c, last_wr_c;
  step_res_t        res;

  assign start_edge_c = START & ~start_q;
  assign last_rd_c    = rd_en_q && (rd_addr_q == AW'(DEPTH - 1));
  assign last_wr_c    = wr_en_q && (wr_addr_q == AW'(DEPTH - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge_c) state_d = SWEEP;
      SWEEP:   if (last_rd_c)    state_d = DRAIN;
      DRAIN:   if (last_wr_c)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Read issue, sweep-start latching and status flags.
  always_comb begin
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    step_d    = step_q;
    enable_d  = enable_q;
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == DRAIN) && last_wr_c;
    overrun_d = overrun_q | (start_edge_c && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (start_edge_c) begin
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          step_d    = STEP;
          enable_d  = ENABLE;
        end
      end
      SWEEP: begin
        if (!last_rd_c) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      v1_q      <= 1'b0;
      a1_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      step_q    <= '0;
      enable_q  <= 1'b0;
    end else begin
      start_q   <= START;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      v1_q      <= rd_en_q;
      a1_q      <= rd_addr_q;
      wr_en_q   <= v1_q;
      wr_addr_q <= a1_q;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      step_q    <= step_d;
      enable_q  <= enable_d;
    end
  end

  silent_step_unit u_step (
    .clk_i       (CLK),
    .rst_i       (RST),
    .en_i        (v1_q),
    .enable_i    (enable_q),
    .step_i      (step_q),
    .cycle_i     (CYCLE),
    .cur_duty_i  (CUR_DUTY),
    .cur_phase_i (CUR_PHASE),
    .tgt_duty_i  (TGT_DUTY),
    .tgt_phase_i (TGT_PHASE),
    .res_o       (res)
  );

  assign RD_EN    = rd_en_q;
  assign RD_ADDR  = rd_addr_q;
  assign WR_EN    = wr_en_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DUTY  = res.duty;
  assign WR_PHASE = res.phase;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_silent_step_scheduler.sv
// Bench for silent_step_scheduler: RAM models plus an arithmetic reference of
// the duty/phase stepping rules, checked sweep by sweep.
module tb_silent_step_scheduler;

  localparam int unsigned W     = 13;
  localparam int unsigned DEPTH = 249;
  localparam int unsigned AW    = 8;

  logic          CLK, RST, START, ENABLE;
  logic [W-1:0]  STEP;
  logic          RD_EN, WR_EN, BUSY, DONE, OVERRUN;
  logic [AW-1:0] RD_ADDR, WR_ADDR;
  logic [W-1:0]  TGT_DUTY, TGT_PHASE, CYCLE, CUR_DUTY, CUR_PHASE, WR_DUTY, WR_PHASE;

  int  t_duty [DEPTH];
  int  t_phase[DEPTH];
  int  t_cyc  [DEPTH];
  int  c_duty [DEPTH];
  int  c_phase[DEPTH];
  int  ini_duty [DEPTH];
  int  ini_phase[DEPTH];
  bit  load_req;

  int  checks = 0;
  int  errors = 0;
  int  step_v;
  bit  en_v;

  silent_step_scheduler dut (
    .CLK(CLK), .RST(RST), .START(START), .ENABLE(ENABLE), .STEP(STEP),
    .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
    .TGT_DUTY(TGT_DUTY), .TGT_PHASE(TGT_PHASE), .CYCLE(CYCLE),
    .CUR_DUTY(CUR_DUTY), .CUR_PHASE(CUR_PHASE),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DUTY(WR_DUTY), .WR_PHASE(WR_PHASE),
    .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous-read target/state RAMs; state RAM also accepts a bulk preload.
  always @(posedge CLK) begin
    if (RD_EN) begin
      TGT_DUTY  <= W'(t_duty[RD_ADDR]);
      TGT_PHASE <= W'(t_phase[RD_ADDR]);
      CYCLE     <= W'(t_cyc[RD_ADDR]);
      CUR_DUTY  <= W'(c_duty[RD_ADDR]);
      CUR_PHASE <= W'(c_phase[RD_ADDR]);
    end
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        c_duty[i]  <= ini_duty[i];
        c_phase[i] <= ini_phase[i];
      end
    end else if (WR_EN) begin
      c_duty[WR_ADDR]  <= int'(WR_DUTY);
      c_phase[WR_ADDR] <= int'(WR_PHASE);
    end
  end

  function automatic int ref_duty(input int c, input int t, input int s, input bit en);
    int d;
    if (!en) return t;
    d = t - c;
    if (((d < 0) ? -d : d) <= s) return t;
    return (d > 0) ? c + s : c - s;
  endfunction

  function automatic int ref_phase(input int c, input int t, input int cy, input int s, input bit en);
    int f, r;
    if (!en) return t;
    f = (((t - c) % cy) + cy) % cy;
    if (f == 0) return t;
    if (f <= cy / 2) begin
      if (f <= s) return t;
      r = c + s;
      if (r >= cy) r = r - cy;
    end else begin
      if (cy - f <= s) return t;
      r = c - s;
      if (r < 0) r = r + cy;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_state();
    load_req = 1'b1;
    @(posedge CLK);
    #1 load_req = 1'b0;
  endtask

  // One full sweep with timing and data checks; ovr_at < 0 means no second edge.
  task automatic do_sweep(input int hold, input int ovr_at);
    int ed[DEPTH];
    int ep[DEPTH];
    int wr_cnt, busy_cnt, done_cnt, first_rd, first_wr, last_wr, done_n, order_bad, bad;
    for (int i = 0; i < DEPTH; i++) begin
      ed[i] = ref_duty(c_duty[i], t_duty[i], step_v, en_v);
      ep[i] = ref_phase(c_phase[i], t_phase[i], t_cyc[i], step_v, en_v);
    end
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0; order_bad = 0; bad = 0;
    first_rd = -1; first_wr = -1; last_wr = -1; done_n = -1;
    @(negedge CLK);
    STEP = W'(step_v); ENABLE = en_v; START = 1'b1;
    for (int n = 0; n < DEPTH + 12; n++) begin
      @(posedge CLK); #1;
      if (n == hold - 1) START = 1'b0;
      if (n == 1) begin STEP = W'($urandom_range(0, 8191)); ENABLE = ~en_v; end
      if (ovr_at >= 0 && n == ovr_at) START = 1'b1;
      if (ovr_at >= 0 && n == ovr_at + 1) START = 1'b0;
      if (RD_EN && first_rd < 0) first_rd = n;
      if (WR_EN) begin
        if (first_wr < 0) first_wr = n;
        if (int'(WR_ADDR) != wr_cnt) order_bad++;
        wr_cnt++;
        last_wr = n;
      end
      if (BUSY) busy_cnt++;
      if (DONE) begin done_cnt++; done_n = n; end
    end
    for (int i = 0; i < DEPTH; i++)
      if (c_duty[i] != ed[i] || c_phase[i] != ep[i]) bad++;
    chk("first_read_cycle", first_rd, 0);
    chk("first_write_cycle", first_wr, 2);
    chk("write_count", wr_cnt, DEPTH);
    chk("write_span", last_wr - first_wr, DEPTH - 1);
    chk("write_order_errs", order_bad, 0);
    chk("busy_cycles", busy_cnt, DEPTH + 2);
    chk("done_pulses", done_cnt, 1);
    chk("done_cycle", done_n, DEPTH + 2);
    chk("model_bad_entries", bad, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, int'(RD_EN), 0);
    chk({tag, "_rd_addr"}, int'(RD_ADDR), 0);
    chk({tag, "_wr_en"}, int'(WR_EN), 0);
    chk({tag, "_wr_addr"}, int'(WR_ADDR), 0);
    chk({tag, "_wr_data"}, int'({WR_DUTY, WR_PHASE}), 0);
    chk({tag, "_busy_done_ovr"}, int'({BUSY, DONE, OVERRUN}), 0);
  endtask

  task automatic count_at_target(output int bad);
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (c_duty[i] != t_duty[i] || c_phase[i] != t_phase[i]) bad++;
  endtask

  task automatic randomize_targets(input int cy_fixed);
    for (int i = 0; i < DEPTH; i++) begin
      t_cyc[i]   = (cy_fixed > 0) ? cy_fixed : int'($urandom_range(2, 8191));
      t_phase[i] = int'($urandom_range(0, t_cyc[i] - 1));
      t_duty[i]  = int'($urandom_range(0, (cy_fixed > 0) ? cy_fixed - 1 : 8191));
    end
  endtask

  initial begin
    int bad, found;
    int sd[DEPTH];
    int sp[DEPTH];
    int ed[DEPTH];
    int ep[DEPTH];
    RST = 1'b0; START = 1'b0; ENABLE = 1'b1; STEP = '0; load_req = 1'b0;
    TGT_DUTY = '0; TGT_PHASE = '0; CYCLE = W'(5000); CUR_DUTY = '0; CUR_PHASE = '0;

    // Directed duty/phase corner entries 0..4, random elsewhere.
    randomize_targets(5000);
    for (int i = 0; i < DEPTH; i++) begin
      ini_duty[i]  = int'($urandom_range(0, 4999));
      ini_phase[i] = int'($urandom_range(0, 4999));
    end
    t_duty[0] = 250;  ini_duty[0] = 0;    t_phase[0] = 10; ini_phase[0] = 10;
    t_duty[1] = 250;  ini_duty[1] = 300;  t_phase[1] = 20; ini_phase[1] = 20;
    t_duty[2] = 7;    ini_duty[2] = 7;    t_phase[2] = 50;   ini_phase[2] = 4950;
    t_duty[3] = 8;    ini_duty[3] = 8;    t_phase[3] = 200;  ini_phase[3] = 4950;
    t_duty[4] = 9;    ini_duty[4] = 9;    t_phase[4] = 4900; ini_phase[4] = 100;

    #3 RST = 1'b1;
    load_state();
    repeat (2) @(posedge CLK);
    #1 check_all_zero("in_reset");
    @(negedge CLK) RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 check_all_zero("after_reset");

    step_v = 100; en_v = 1'b1;
    do_sweep(1, -1);
    chk("duty0_sweep1", c_duty[0], 100);
    chk("duty1_down_clamp", c_duty[1], 250);
    chk("phase2_wrap_exact", c_phase[2], 50);
    chk("phase3_wrap_step", c_phase[3], 50);
    chk("phase4_back_step", c_phase[4], 0);
    do_sweep(1, -1);
    chk("duty0_sweep2", c_duty[0], 200);
    chk("phase4_back_wrap", c_phase[4], 4900);
    do_sweep(1, -1);
    chk("duty0_sweep3", c_duty[0], 250);
    do_sweep(1, -1);
    chk("duty0_sweep4", c_duty[0], 250);

    // STEP=0 leaves state unchanged.
    for (int i = 0; i < DEPTH; i++) begin sd[i] = c_duty[i]; sp[i] = c_phase[i]; end
    step_v = 0; en_v = 1'b1;
    do_sweep(1, -1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (c_duty[i] != sd[i] || c_phase[i] != sp[i]) bad++;
    chk("step0_changed", bad, 0);

    // Bypass: one sweep reaches the targets.
    randomize_targets(5000);
    step_v = 100; en_v = 1'b0;
    do_sweep(1, -1);
    count_at_target(bad);
    chk("bypass_not_at_target", bad, 0);

    // Smoothing convergence within 51 sweeps.
    randomize_targets(5000);
    step_v = 100; en_v = 1'b1;
    for (int s = 0; s < 51; s++) do_sweep(1, -1);
    count_at_target(bad);
    chk("converge_not_at_target", bad, 0);

    // Random cycles and steps.
    for (int r = 0; r < 3; r++) begin
      randomize_targets(0);
      for (int i = 0; i < DEPTH; i++) begin
        ini_duty[i]  = int'($urandom_range(0, 8191));
        ini_phase[i] = int'($urandom_range(0, t_cyc[i] - 1));
      end
      load_state();
      step_v = int'($urandom_range(0, 3000)); en_v = 1'b1;
      do_sweep(1, -1);
    end

    // START held for several cycles gives one sweep.
    step_v = 100; en_v = 1'b1;
    do_sweep(4, -1);
    chk("overrun_clear_before", int'(OVERRUN), 0);

    // Second edge mid-sweep is ignored but sticky-flagged.
    do_sweep(1, 50);
    chk("overrun_set", int'(OVERRUN), 1);
    do_sweep(1, -1);
    chk("overrun_sticky", int'(OVERRUN), 1);

    // Reset right after write of entry 120 lands.
    randomize_targets(5000);
    for (int i = 0; i < DEPTH; i++) begin
      sd[i] = c_duty[i]; sp[i] = c_phase[i];
      ed[i] = ref_duty(c_duty[i], t_duty[i], 100, 1'b1);
      ep[i] = ref_phase(c_phase[i], t_phase[i], t_cyc[i], 100, 1'b1);
    end
    found = 0;
    @(negedge CLK);
    STEP = W'(100); ENABLE = 1'b1; START = 1'b1;
    for (int n = 0; n < 400 && found == 0; n++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      if (WR_EN && WR_ADDR == AW'(120)) found = 1;
    end
    chk("reset_point_found", found, 1);
    @(posedge CLK); #1 RST = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge CLK) RST = 1'b0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i <= 120 && (c_duty[i] != ed[i] || c_phase[i] != ep[i])) bad++;
      if (i > 120 && (c_duty[i] != sd[i] || c_phase[i] != sp[i])) bad++;
    end
    chk("partial_sweep_entries", bad, 0);
    step_v = 100; en_v = 1'b1;
    do_sweep(1, -1);
    chk("overrun_after_rst", int'(OVERRUN), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
